// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (inhibit, request-to-send, device-clocked shift, line ACK).
// Optional macro PS2_TX_ACK_WAIT_EN: also wait for the keyboard response byte (0xFA accepts, anything else fails).
//
// state      | meaning
// IDLE       | both lines released, waiting for send
// INHIBIT    | PS2_CLK held low by the host
// WAIT_FIRST | start bit on PS2_DAT, clock released, waiting for first device falling edge
// SHIFT      | data/parity/stop presented on device falling edges, line ACK sampled on edge 11
// WAIT_IDLE  | waiting for both lines to return high
// WAIT_RESP  | waiting for the response byte (PS2_TX_ACK_WAIT_EN only)
// SUCCESS    | one-cycle done pulse
// FAIL       | one-cycle error pulse, lines released
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES       = 5000,
  parameter int unsigned START_TIMEOUT_CYCLES = 750000,
  parameter int unsigned BIT_TIMEOUT_CYCLES   = 100000,
  parameter int unsigned RESP_TIMEOUT_CYCLES  = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  input  logic       send,
  input  logic [7:0] command,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] resp
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_INHIBIT    = 3'd1;
  localparam logic [2:0] S_WAIT_FIRST = 3'd2;
  localparam logic [2:0] S_SHIFT      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE  = 3'd4;
  localparam logic [2:0] S_WAIT_RESP  = 3'd5;
  localparam logic [2:0] S_SUCCESS    = 3'd6;
  localparam logic [2:0] S_FAIL       = 3'd7;

  // Only one phase is ever timed at once, so a single timer sized for the largest limit serves all.
  localparam int unsigned LIM_A = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int unsigned LIM_B = (BIT_TIMEOUT_CYCLES > RESP_TIMEOUT_CYCLES) ? BIT_TIMEOUT_CYCLES : RESP_TIMEOUT_CYCLES;
  localparam int unsigned LIM_MAX = (LIM_A > LIM_B) ? LIM_A : LIM_B;
  localparam int TW = $clog2(LIM_MAX) + 1;

  localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LIM = TW'(START_TIMEOUT_CYCLES);
  localparam logic [TW-1:0] BIT_LIM   = TW'(BIT_TIMEOUT_CYCLES);
`ifdef PS2_TX_ACK_WAIT_EN
  localparam logic [TW-1:0] RESP_LIM  = TW'(RESP_TIMEOUT_CYCLES);
`endif

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [3:0]    edge_cnt;
  logic [7:0]    cmd_q;
  logic          parity_q;
  logic          clk_oe;
  logic          dat_oe;
  logic          clk_meta, sync_clk, sync_clk_d;
  logic          dat_meta, sync_dat;
  logic          clk_fall;

  assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_meta   <= 1'b1;
      sync_clk   <= 1'b1;
      sync_clk_d <= 1'b1;
      dat_meta   <= 1'b1;
      sync_dat   <= 1'b1;
    end else begin
      clk_meta   <= PS2_CLK;
      sync_clk   <= clk_meta;
      sync_clk_d <= sync_clk;
      dat_meta   <= PS2_DAT;
      sync_dat   <= dat_meta;
    end
  end

  assign clk_fall = sync_clk_d & ~sync_clk;

`ifdef PS2_TX_ACK_WAIT_EN
  logic [7:0] resp_q;
  assign resp = resp_q;
`else
  wire unused_rx = ^{rx_data, rx_valid};
  assign resp = 8'h00;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      edge_cnt <= '0;
      cmd_q    <= '0;
      parity_q <= 1'b0;
      clk_oe   <= 1'b0;
      dat_oe   <= 1'b0;
`ifdef PS2_TX_ACK_WAIT_EN
      resp_q   <= 8'h00;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (send) begin
            cmd_q    <= command;
            parity_q <= ~^command;
            timer    <= '0;
            edge_cnt <= '0;
            clk_oe   <= 1'b1;
            state    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (timer >= INH_LAST) begin
            clk_oe <= 1'b0;
            dat_oe <= 1'b1;
            timer  <= '0;
            state  <= S_WAIT_FIRST;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT_FIRST: begin
          if (clk_fall) begin
            dat_oe   <= ~cmd_q[0];
            edge_cnt <= 4'd1;
            timer    <= '0;
            state    <= S_SHIFT;
          end else if (timer >= START_LIM) begin
            dat_oe <= 1'b0;
            state  <= S_FAIL;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_SHIFT: begin
          if (clk_fall) begin
            // edge_cnt holds the previous edge number; this edge presents command[edge_cnt]
            edge_cnt <= edge_cnt + 4'd1;
            timer    <= '0;
            if (edge_cnt <= 4'd7) begin
              dat_oe <= ~cmd_q[edge_cnt[2:0]];
            end else if (edge_cnt == 4'd8) begin
              dat_oe <= ~parity_q;
            end else if (edge_cnt == 4'd9) begin
              dat_oe <= 1'b0;
            end else if (sync_dat) begin
              state <= S_FAIL;
            end else begin
              state <= S_WAIT_IDLE;
            end
          end else if (timer >= BIT_LIM) begin
            dat_oe <= 1'b0;
            state  <= S_FAIL;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (sync_clk && sync_dat) begin
            timer <= '0;
`ifdef PS2_TX_ACK_WAIT_EN
            state <= S_WAIT_RESP;
`else
            state <= S_SUCCESS;
`endif
          end else if (timer >= BIT_LIM) begin
            state <= S_FAIL;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef PS2_TX_ACK_WAIT_EN
        S_WAIT_RESP: begin
          if (rx_valid) begin
            resp_q <= rx_data;
            state  <= (rx_data == 8'hFA) ? S_SUCCESS : S_FAIL;
          end else if (timer >= RESP_LIM) begin
            state <= S_FAIL;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        S_SUCCESS: state <= S_IDLE;
        S_FAIL: begin
          clk_oe <= 1'b0;
          dat_oe <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          clk_oe <= 1'b0;
          dat_oe <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = (state != S_IDLE) && (state != S_SUCCESS) && (state != S_FAIL);
  assign done  = (state == S_SUCCESS);
  assign error = (state == S_FAIL);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: keyboard BFM on the open-drain lines, outcome scoreboard, per-cycle checker.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH      = 40;
  localparam int START_TO = 300;
  localparam int BIT_TO   = 150;
  localparam int RESP_TO  = 400;
`ifdef PS2_TX_ACK_WAIT_EN
  localparam bit ACKW = 1'b1;
`else
  localparam bit ACKW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] command = 8'h00;
  logic [7:0] rx_data = 8'h00;
  logic       busy, done, error;
  logic [7:0] resp;
  wire        ps2_clk, ps2_dat;
  logic       bfm_clk_low = 1'b0;
  logic       bfm_dat_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = bfm_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = bfm_dat_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT_CYCLES(START_TO),
    .BIT_TIMEOUT_CYCLES(BIT_TO), .RESP_TIMEOUT_CYCLES(RESP_TO)
  ) dut (
    .clock(clk), .reset(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .send(send), .command(command), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .done(done), .error(error), .resp(resp)
  );

  typedef struct packed { logic ok; logic [7:0] rbyte; } exp_t;
  exp_t        exp_q[$];
  logic [7:0]  model_resp = 8'h00;
  logic [10:0] cap;
  int total = 0, bad = 0, n_pulses = 0, pulse_cyc = 0, cyc = 0;
  logic prev_pulse = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // per-cycle checker, sampled after the lines have settled
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (done || error) begin
      check("pulse_exclusive", done & error, 0);
      check("busy_low_at_pulse", busy, 0);
      check("pulse_single_cycle", prev_pulse, 0);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse: done=%0d error=%0d with nothing outstanding", done, error);
      end else begin
        e = exp_q.pop_front();
        check("outcome_done", done, e.ok);
        check("outcome_error", error, !e.ok);
        check("resp_at_pulse", resp, e.rbyte);
      end
      n_pulses++;
      pulse_cyc = cyc;
    end
    if (!busy && !bfm_clk_low && !bfm_dat_low) begin
      check("idle_clk_released", ps2_clk, 1);
      check("idle_dat_released", ps2_dat, 1);
    end
`ifndef PS2_TX_ACK_WAIT_EN
    check("resp_zero", resp, 0);
`endif
    prev_pulse = done || error;
  end

  // mode: 0 device ACKs, 1 device NACKs, 2 device never clocks; abort_at>0 asserts reset at that falling edge
  task automatic run_txn(input logic [7:0] cmd, input int mode, input int half,
                         input logic [7:0] rxb, input bit noise, input int abort_at);
    int cnt, start_pulses, rel_cyc;
    logic [10:0] exp_frame;
    logic par, ok;
    cnt = 0;
    while (busy && cnt < 5000) begin @(negedge clk); cnt++; end
    check("idle_before_send", busy, 0);
    par = ($countones(cmd) % 2 == 0);
    exp_frame = {1'b1, par, cmd, 1'b0};
    if (abort_at == 0) begin
      ok = (mode == 0) && (!ACKW || rxb == 8'hFA);
      if (ACKW && mode == 0) model_resp = rxb;
      exp_q.push_back(exp_t'({ok, model_resp}));
    end
    start_pulses = n_pulses;
    @(negedge clk); send = 1'b1; command = cmd;
    @(negedge clk); send = 1'b0; command = 8'($urandom);
    check("busy_rise", busy, 1);
    cnt = 0;
    while (ps2_clk == 1'b0 && cnt < INH + 100) begin cnt++; @(negedge clk); end
    check("inhibit_len", cnt, INH);
    check("rts_start_bit", ps2_dat, 0);
    cap = '1;
    cap[0] = ps2_dat;
    rel_cyc = cyc;
    if (mode == 2) begin
      cnt = 0;
      while (n_pulses == start_pulses && cnt < START_TO + 100) begin @(negedge clk); cnt++; end
      check("start_timeout_seen", n_pulses - start_pulses, 1);
      check_range("start_timeout_latency", pulse_cyc - rel_cyc, START_TO - 3, START_TO + 3);
      @(negedge clk);
      check("timeout_clk_released", ps2_clk, 1);
      check("timeout_dat_released", ps2_dat, 1);
      return;
    end
    repeat ($urandom_range(5, 30)) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && mode == 0) begin
        bfm_dat_low = 1'b1;
        repeat (4) @(negedge clk);
      end
      bfm_clk_low = 1'b1;
      if (noise && i == 3) begin
        check("busy_during_noise", busy, 1);
        send = 1'b1; command = 8'($urandom);
        @(negedge clk);
        send = 1'b0;
        repeat (half - 1) @(negedge clk);
      end else if (i == abort_at) begin
        repeat (6) @(negedge clk);
        check("pre_reset_drive", ps2_dat, cmd[i-1]);
        rst_n = 1'b0;
        #1;
        check("reset_dat_released", ps2_dat, 1);
        check("reset_busy_low", busy, 0);
        bfm_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_clk_released", ps2_clk, 1);
        return;
      end else begin
        repeat (half) @(negedge clk);
      end
      if (i <= 10) cap[i] = ps2_dat;
      bfm_clk_low = 1'b0;
      if (i == 11) bfm_dat_low = 1'b0;
      repeat (half) @(negedge clk);
    end
    check("frame_bits", cap, exp_frame);
    if (mode == 0) begin
      repeat (6) @(negedge clk);
      rx_valid = 1'b1; rx_data = rxb;
      @(negedge clk);
      rx_valid = 1'b0; rx_data = 8'($urandom);
    end
    cnt = 0;
    while (n_pulses == start_pulses && cnt < RESP_TO + 200) begin @(negedge clk); cnt++; end
    check("outcome_seen", n_pulses - start_pulses, 1);
    if (noise) begin
      repeat (INH * 3) @(negedge clk);
      check("no_requeue_busy", busy, 0);
      check("no_requeue_pulses", n_pulses - start_pulses, 1);
    end
  endtask

  initial begin
    int mode, half;
    logic [7:0] rxb;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_resp", resp, 0);
    check("reset_clk_hiz", ps2_clk, 1);
    check("reset_dat_hiz", ps2_dat, 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_txn(8'hED, 0, 10, 8'hFA, 1'b0, 0);
    check("ed_frame_literal", cap, 11'h7DA);
    run_txn(8'h07, 0, 12, 8'hFA, 1'b1, 0);
    check("parity_07", cap[9], 0);
    run_txn(8'h00, 0, 9, 8'hFA, 1'b0, 0);
    check("parity_00", cap[9], 1);
    run_txn(8'hF3, 2, 10, 8'h00, 1'b0, 0);
    run_txn(8'hFF, 1, 10, 8'h00, 1'b0, 0);
    run_txn(8'hED, 0, 10, 8'hFA, 1'b0, 5);
    run_txn(8'hFF, 0, 10, 8'hFA, 1'b0, 0);
    check("ff_frame_literal", cap, 11'h7FE);
`ifdef PS2_TX_ACK_WAIT_EN
    run_txn(8'hED, 0, 10, 8'hFE, 1'b0, 0);
    check("resp_fe_literal", resp, 8'hFE);
    run_txn(8'hED, 0, 10, 8'hFA, 1'b0, 0);
    check("resp_fa_literal", resp, 8'hFA);
`endif
    for (int n = 0; n < 16; n++) begin
      mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
      half = $urandom_range(8, 20);
      rxb  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFA;
      run_txn(8'($urandom), mode, half, rxb, 1'($urandom_range(0, 1)), 0);
    end
    repeat (10) @(negedge clk);
    check("no_outstanding_expect", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF3 typematic) from FPGA to keyboard on the same PS2_CLK/PS2_DAT pins used by the keyboard receive path.
- Runs the inhibit / request-to-send / device-clocked shift / line-ACK sequence.
- Reports completion or failure to the game control logic through a single-command handshake.

Parameters:
- INHIBIT_CYCLES, 5000: cycles PS2_CLK is held low before request-to-send (100 us at 50 MHz).
- START_TIMEOUT_CYCLES, 750000: maximum cycles from clock release to the first device falling edge (15 ms).
- BIT_TIMEOUT_CYCLES, 100000: maximum cycles between consecutive device falling edges (2 ms).
- RESP_TIMEOUT_CYCLES, 1000000: response-byte timeout in cycles; used only with PS2_TX_ACK_WAIT_EN.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- PS2_CLK  inout  1  open-drain: driven 0 or high-Z, never driven 1.
- PS2_DAT  inout  1  open-drain: driven 0 or high-Z, never driven 1.
- send  in  1  start request; sampled only when busy=0.
- command  in  8  byte to transmit; latched on an accepted send.
- rx_data  in  8  byte from the keyboard receive path; used only with the optional feature.
- rx_valid  in  1  one-cycle strobe qualifying rx_data.
- busy  out  1  high from the cycle after acceptance until return to IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on timeout or NACK.
- resp  out  8  last response byte; 0x00 when the optional feature is off.

Behaviour:
- Reset (async, reset=0): both lines high-Z; busy=0, done=0, error=0, resp=0x00; state IDLE; all counters cleared. Asserting reset mid-transfer releases both lines immediately.
- Input synchronisation: PS2_CLK and PS2_DAT each pass through a 2-flop synchroniser. A falling edge is sync_clk 1 -> 0 between consecutive cycles.
- IDLE: if send=1, latch command, compute parity = ~^command (odd parity), enter INHIBIT. busy rises the next cycle.
- INHIBIT: drive PS2_CLK=0 for exactly INHIBIT_CYCLES cycles. Then drive PS2_DAT=0 (start bit), release PS2_CLK, enter WAIT_FIRST.
- WAIT_FIRST: on the first falling edge, drive PS2_DAT = command[0], edge count = 1, enter SHIFT. If START_TIMEOUT_CYCLES elapse without an edge, go to FAIL.
- SHIFT: drive only while the device clock is low.
  - Falling edges 2..8: drive command[1..7] in order.
  - Edge 9: drive parity.
  - Edge 10: release PS2_DAT (stop bit).
  - Edge 11: sample sync_dat. 0 = device ACK -> WAIT_IDLE; 1 = NACK -> FAIL.
  - The inter-edge timer restarts on every edge; expiry of BIT_TIMEOUT_CYCLES -> FAIL.
- WAIT_IDLE: wait until sync_clk=1 and sync_dat=1 (BIT_TIMEOUT applies), then enter SUCCESS.
- SUCCESS: pulse done for one cycle, return to IDLE.
- FAIL: release both lines, pulse error for one cycle, return to IDLE.
- busy falls in the same cycle as the done or error pulse. done and error are never high together.
- send while busy=1 is ignored, not queued. Holding send high re-triggers on the first IDLE cycle.
- The block never drives either line in IDLE, so the keyboard receive path is unaffected between commands.
- Counters are sized by $clog2 of their parameter + 1. Every timeout check is >= the limit.

Optional Feature:
- Macro PS2_TX_ACK_WAIT_EN.
- Defined: after WAIT_IDLE, enter WAIT_RESP and wait for rx_valid.
  - rx_data=0xFA: resp <= 0xFA, SUCCESS.
  - Any other byte: resp <= byte, FAIL.
  - No rx_valid within RESP_TIMEOUT_CYCLES: resp unchanged, FAIL.
- Not defined: WAIT_IDLE goes directly to SUCCESS; rx_data and rx_valid are ignored; resp stays 0x00.

Test Plan:
- Send 0xED, device BFM clocks at 12.5 kHz and ACKs -> PS2_CLK low for exactly 5000 cycles; bits sampled on rising edges are 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once, error stays 0.
- Send 0x07 -> parity bit 0. Send 0x00 -> parity bit 1. Both complete with done.
- BFM never clocks after release -> error pulses 750000 cycles after clock release (±3 for sync latency); both lines high-Z.
- BFM leaves PS2_DAT high at edge 11 (NACK) -> error pulse, busy falls, no done.
- Assert reset during SHIFT at edge 5 -> lines high-Z within the same cycle; busy=0; a subsequent send 0xFF completes normally.
- With PS2_TX_ACK_WAIT_EN defined: rx_valid with 0xFA -> done, resp=0xFA. rx_valid with 0xFE -> error, resp=0xFE. Also: send pulses while busy are ignored, confirmed by exactly 11 device edges per transfer.
